// File: rtl/mux_rr_arb.sv
// mux_rr_arb: N-channel input multiplexer with a registered single-word output.
// The input channel comes either from a fixed index or from round-robin
// arbitration.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   mode       0 = fixed select by sel, 1 = round-robin arbitration
//   sel        channel index used when mode = 0
//   in_valid   per-channel data valid (N bits)
//   in_data    channel i in bits [i*W +: W]
//   in_ready   one-hot accept strobe on the granted channel (combinational)
//   out_valid  the output register holds a word
//   out_data   the registered selected word
//   out_ch     index of the channel that supplied out_data
//   out_ready  downstream accept
//
// Handshake: a channel transfers on a cycle where in_valid[i] && in_ready[i].
// The output transfers when out_valid && out_ready. in_ready is raised only
// when the output register is empty or is being drained in the same cycle
// (load_en). This lets a new word follow a drained one with no bubble.
// Inputs need not hold valid. A valid that is dropped before it is granted
// leaves no trace.
module mux_rr_arb #(
  parameter int N = 8,
  parameter int W = 8,
  localparam int S = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [S-1:0]   sel,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [S-1:0]   out_ch,
  input  logic           out_ready
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [S-1:0] out_ch_q, out_ch_d;
  logic [S-1:0] ptr_q, ptr_d;

  logic         load_en;
  logic         grant;
  logic [S-1:0] grant_ch;
  int           rr_idx;

  // Grant selection. Reset suppresses all accepts, so upstream never sees
  // a word taken that the reset would then discard.
  always_comb begin
    load_en  = !out_valid_q || out_ready;
    grant    = 1'b0;
    grant_ch = '0;
    rr_idx   = 0;
    if (!rst && load_en) begin
      if (!mode) begin
        // An out-of-range sel matches no channel, so there is no grant.
        for (int i = 0; i < N; i++) begin
          if (S'(i) == sel && in_valid[i]) begin
            grant    = 1'b1;
            grant_ch = S'(i);
          end
        end
      end else begin
        // Walk from the farthest offset to the nearest, so the channel
        // nearest to ptr is the last one written and wins.
        for (int k = N - 1; k >= 0; k--) begin
          rr_idx = int'(ptr_q) + k;
          if (rr_idx >= N) rr_idx = rr_idx - N;
          if (in_valid[rr_idx]) begin
            grant    = 1'b1;
            grant_ch = S'(rr_idx);
          end
        end
      end
    end
    in_ready = grant ? (N'(1) << grant_ch) : '0;
  end

  // Next-state for the output register and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[grant_ch*W +: W];
      out_ch_d    = grant_ch;
      if (mode) begin
        // Explicit wrap keeps ptr below N when N is not a power of two.
        ptr_d = (int'(grant_ch) == N - 1) ? '0 : grant_ch + S'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
module tb_mux_rr_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N = 8 instance
  logic        rst8;
  logic        mode8;
  logic [2:0]  sel8;
  logic [7:0]  in_valid8;
  logic [63:0] in_data8;
  logic [7:0]  in_ready8;
  logic        out_valid8;
  logic [7:0]  out_data8;
  logic [2:0]  out_ch8;
  logic        out_ready8;

  // N = 5 instance
  logic        rst5;
  logic        mode5;
  logic [2:0]  sel5;
  logic [4:0]  in_valid5;
  logic [39:0] in_data5;
  logic [4:0]  in_ready5;
  logic        out_valid5;
  logic [7:0]  out_data5;
  logic [2:0]  out_ch5;
  logic        out_ready5;

  int errors = 0;
  int checks = 0;

  mux_rr_arb #(.N(8), .W(8)) dut8 (
    .clk(clk), .rst(rst8), .mode(mode8), .sel(sel8),
    .in_valid(in_valid8), .in_data(in_data8), .in_ready(in_ready8),
    .out_valid(out_valid8), .out_data(out_data8), .out_ch(out_ch8),
    .out_ready(out_ready8)
  );

  mux_rr_arb #(.N(5), .W(8)) dut5 (
    .clk(clk), .rst(rst5), .mode(mode5), .sel(sel5),
    .in_valid(in_valid5), .in_data(in_data5), .in_ready(in_ready5),
    .out_valid(out_valid5), .out_data(out_data5), .out_ch(out_ch5),
    .out_ready(out_ready5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Registered outputs are sampled 1 time unit after the rising edge.
  // New inputs are driven at that point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let the combinational in_ready settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst8 = 1'b1; mode8 = 1'b0; sel8 = '0; in_valid8 = '0; out_ready8 = 1'b1;
    rst5 = 1'b1; mode5 = 1'b0; sel5 = '0; in_valid5 = '0; out_ready5 = 1'b1;
    for (int i = 0; i < 8; i++) in_data8[i*8 +: 8] = 8'hC0 + 8'(i);
    for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'h50 + 8'(i);
    tick();
    tick();

    // Reset state, and no accept while rst is high.
    chk("rst_out_valid", 32'(out_valid8), 32'h0);
    chk("rst_out_data",  32'(out_data8),  32'h0);
    chk("rst_out_ch",    32'(out_ch8),    32'h0);
    chk("rst_ptr",       32'(dut8.ptr_q), 32'h0);
    mode8 = 1'b1; in_valid8 = 8'hFF;
    settle();
    chk("rst_in_ready", 32'(in_ready8), 32'h0);
    tick();
    chk("rst_no_load", 32'(out_valid8), 32'h0);

    // Fixed select: sel=5, channel 5 carries A5.
    rst8 = 1'b0; mode8 = 1'b0; sel8 = 3'd5; in_valid8 = 8'h20;
    in_data8[5*8 +: 8] = 8'hA5;
    settle();
    chk("fix_in_ready", 32'(in_ready8), 32'h20);
    tick();
    chk("fix_out_valid", 32'(out_valid8), 32'h1);
    chk("fix_out_data",  32'(out_data8),  32'hA5);
    chk("fix_out_ch",    32'(out_ch8),    32'h5);
    chk("fix_ptr_hold",  32'(dut8.ptr_q), 32'h0);
    in_valid8 = 8'h00;
    settle();
    chk("drain_in_ready", 32'(in_ready8), 32'h0);
    tick();
    chk("drain_out_valid", 32'(out_valid8), 32'h0);
    chk("drain_data_hold", 32'(out_data8),  32'hA5);
    chk("drain_ch_hold",   32'(out_ch8),    32'h5);

    // Round-robin from reset with every channel valid.
    in_data8[5*8 +: 8] = 8'hC5;
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0; mode8 = 1'b1; in_valid8 = 8'hFF;
    settle();
    chk("rr_first_ready", 32'(in_ready8), 32'h01);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("rr_seq_valid", 32'(out_valid8), 32'h1);
      chk("rr_seq_ch",    32'(out_ch8),    32'(k % 8));
      chk("rr_seq_data",  32'(out_data8),  32'h0C0 + 32'(k % 8));
    end

    // Wrap test: ptr=1, then in_valid=81 grants 7, then 0, then 7.
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0; in_valid8 = 8'h01;
    settle();
    chk("wrap_pre_ready", 32'(in_ready8), 32'h01);
    tick();
    chk("wrap_ptr1", 32'(dut8.ptr_q), 32'h1);
    in_valid8 = 8'h81;
    settle();
    chk("wrap_ready7a", 32'(in_ready8), 32'h80);
    tick();
    chk("wrap_ch7a",  32'(out_ch8),    32'h7);
    chk("wrap_ptr0a", 32'(dut8.ptr_q), 32'h0);
    settle();
    chk("wrap_ready0", 32'(in_ready8), 32'h01);
    tick();
    chk("wrap_ch0",   32'(out_ch8),    32'h0);
    chk("wrap_ptr1b", 32'(dut8.ptr_q), 32'h1);
    settle();
    chk("wrap_ready7b", 32'(in_ready8), 32'h80);
    tick();
    chk("wrap_ch7b",  32'(out_ch8),    32'h7);
    chk("wrap_ptr0b", 32'(dut8.ptr_q), 32'h0);

    // Stall for 3 cycles with the word from channel 7 held.
    out_ready8 = 1'b0; in_valid8 = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("stall_in_ready", 32'(in_ready8), 32'h0);
      tick();
      chk("stall_valid", 32'(out_valid8), 32'h1);
      chk("stall_ch",    32'(out_ch8),    32'h7);
      chk("stall_data",  32'(out_data8),  32'hC7);
      chk("stall_ptr",   32'(dut8.ptr_q), 32'h0);
    end
    out_ready8 = 1'b1;
    settle();
    chk("unstall_ready", 32'(in_ready8), 32'h01);
    tick();
    chk("unstall_valid", 32'(out_valid8), 32'h1);
    chk("unstall_ch",    32'(out_ch8),    32'h0);
    chk("unstall_data",  32'(out_data8),  32'hC0);

    // A mode change applies to the same cycle's grant. ptr holds.
    mode8 = 1'b0; sel8 = 3'd3;
    settle();
    chk("modechg_ready", 32'(in_ready8), 32'h08);
    tick();
    chk("modechg_ch",  32'(out_ch8),    32'h3);
    chk("modechg_ptr", 32'(dut8.ptr_q), 32'h1);

    // Reset while holding 3C discards the word. Then round-robin starts at 0.
    sel8 = 3'd2; in_data8[2*8 +: 8] = 8'h3C;
    tick();
    chk("pre_rst_data",  32'(out_data8),  32'h3C);
    chk("pre_rst_valid", 32'(out_valid8), 32'h1);
    rst8 = 1'b1;
    tick();
    chk("post_rst_valid", 32'(out_valid8), 32'h0);
    chk("post_rst_data",  32'(out_data8),  32'h0);
    chk("post_rst_ch",    32'(out_ch8),    32'h0);
    rst8 = 1'b0; mode8 = 1'b1; in_valid8 = 8'hFF;
    settle();
    chk("post_rst_ready", 32'(in_ready8), 32'h01);
    tick();
    chk("post_rst_first_ch", 32'(out_ch8), 32'h0);
    chk("post_rst_first_v",  32'(out_valid8), 32'h1);

    // N=5: grant channel 1 so that ptr=2.
    rst5 = 1'b0; mode5 = 1'b1; in_valid5 = 5'h02;
    settle();
    chk("n5_ready1", 32'(in_ready5), 32'h02);
    tick();
    chk("n5_ptr2", 32'(dut5.ptr_q), 32'h2);
    chk("n5_data1", 32'(out_data5), 32'h51);
    // N=5: sel=6 is out of range, so there is no grant and ptr holds.
    mode5 = 1'b0; sel5 = 3'd6; in_valid5 = 5'h1F;
    settle();
    chk("n5_oor_ready", 32'(in_ready5), 32'h0);
    tick();
    chk("n5_oor_valid", 32'(out_valid5), 32'h0);
    chk("n5_oor_ptr",   32'(dut5.ptr_q), 32'h2);
    tick();
    chk("n5_oor_valid2", 32'(out_valid5), 32'h0);
    // N=5: a grant of channel 4 wraps ptr to 0.
    mode5 = 1'b1; in_valid5 = 5'h10;
    settle();
    chk("n5_ready4", 32'(in_ready5), 32'h10);
    tick();
    chk("n5_ch4",     32'(out_ch5),     32'h4);
    chk("n5_ptr_wrap", 32'(dut5.ptr_q), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_arb.md
MUX_RR_ARB -- requirements
Module: mux_rr_arb

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the number of input channels (legal range 2..16).
REQ-002 The block SHALL have parameter W, default 8, giving the data width per channel in bits.
REQ-003 The block SHALL have localparam S = clog2(N), giving the select/channel-index width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = fixed select, 1 = round-robin arbitration.
REQ-007 The block SHALL have port sel, input, S bits: channel index used when mode=0.
REQ-008 The block SHALL have port in_valid, input, N bits: per-channel data-valid.
REQ-009 The block SHALL have port in_data, input, N*W bits: channel i occupies bits [i*W +: W].
REQ-010 The block SHALL have port in_ready, output, N bits: per-channel accept strobe.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the output register holds a word.
REQ-012 The block SHALL have port out_data, output, W bits: the registered selected word.
REQ-013 The block SHALL have port out_ch, output, S bits: index of the channel that supplied out_data.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accepts when out_valid && out_ready.

Function
REQ-015 The block SHALL define load_en = !out_valid || out_ready, combinationally.
REQ-016 In mode=0, the block SHALL grant channel sel iff load_en && sel < N && in_valid[sel]; otherwise there is no grant.
REQ-017 In mode=1, the block SHALL grant the first channel with in_valid set, searching ptr, ptr+1, ... with wrap-around modulo N, iff load_en and any in_valid is set.
REQ-018 The block SHALL drive in_ready as one-hot on the granted channel, and all-zero when there is no grant; in_ready SHALL be combinational from current inputs and state.
REQ-019 On a grant to channel g, the next edge SHALL load out_data <= in_data[g], out_ch <= g, and out_valid <= 1; load latency is one cycle from the accept.
REQ-020 When out_valid && out_ready and there is no grant, the next edge SHALL clear out_valid; out_data and out_ch SHALL hold their values.
REQ-021 While out_valid && !out_ready, the block SHALL keep out_data, out_ch and out_valid stable, and in_ready SHALL be all-zero.
REQ-022 On a simultaneous downstream accept and new grant, the block SHALL load the new word with no bubble, sustaining one word per cycle.
REQ-023 The round-robin pointer ptr (S bits) SHALL update to (g+1) mod N on every mode=1 grant; g = N-1 wraps to 0.
REQ-024 On mode=0 grants and on cycles with no grant, ptr SHALL hold its value.
REQ-025 A change of mode or sel SHALL take effect combinationally on the same cycle's grant; an already-loaded out_data SHALL be unaffected.
REQ-026 For N not a power of two, mode=0 with sel >= N SHALL produce no grant, and ptr SHALL never take a value >= N.
REQ-027 An in_valid bit deasserted without a grant SHALL have no effect on the output; the block does not require inputs to hold valid.

Reset
REQ-028 When rst=1 at a rising edge, the next state SHALL be out_valid=0, out_data=0, out_ch=0 and ptr=0, regardless of other inputs.
REQ-029 While rst=1, in_ready SHALL be all-zero, and no word accepted in that cycle SHALL be lost by upstream (no accept is signalled).
REQ-030 Reset asserted with out_valid=1 SHALL discard the held word; the first cycle after rst deasserts SHALL behave as empty (load_en=1).

Verification
REQ-031 Test: N=8, W=8, mode=0, sel=5, in_valid=8'h20, in_data[5]=8'hA5, out_ready=1 -> in_ready=8'h20 that cycle; next cycle out_valid=1, out_data=8'hA5, out_ch=5.
REQ-032 Test: mode=1, in_valid=8'hFF held, out_ready=1 for 10 cycles from reset -> out_ch sequence 0,1,2,...,7,0,1 with out_valid high every cycle.
REQ-033 Test: mode=1, in_valid=8'h81, ptr=1 -> grant 7, then 0, then 7; ptr wraps 7->0 correctly.
REQ-034 Test: out_valid=1 with out_ready=0 for 3 cycles while in_valid=8'hFF -> in_ready=0 and out_data/out_ch stable; out_ready=1 -> same-cycle new grant, no bubble.
REQ-035 Test: N=5, mode=0, sel=6, in_valid=5'h1F -> no grant, out_valid stays 0, ptr unchanged.
REQ-036 Test: rst=1 while out_valid=1, out_data=8'h3C -> next cycle out_valid=0, out_data=0, out_ch=0; then mode=1 with all valid -> first grant is channel 0.
